irq_priority_ctrl: RTL and testbench
====================================

// Module: irq_priority_ctrl
// PURPOSE
//  Machine-level interrupt controller in front of the core FSM.
//  - Latches up to NUM_SRC interrupt sources (timer, external, software) into a pending vector.
//  - Masks them with CSR enable bits (mie) and the global enable (mstatus.MIE).
//  - Picks one by fixed priority, presents a single request plus mcause value, and tracks
//    it in service until MRET.
//  - Replaces the single timer_timeout path into the core FSM.
// PARAMETERS
//  NUM_SRC    8           number of interrupt sources, 2..16
//  EDGE_MASK  8'b00000001 per-source type: 1 = rising-edge latched, 0 = level
//  CAUSE_BASE 16          mcause code of source 0; source i reports CAUSE_BASE+i
//  ID_W       4           width of the source index, >= clog2(NUM_SRC)
// PORTS
//  clk           in   1            clock
//  reset         in   1            synchronous, active-high reset
//  irq_src_i     in   NUM_SRC      raw interrupt lines, synchronous to clk
//  enable_mask_i in   NUM_SRC      per-source enable (mie image)
//  global_en_i   in   1            global interrupt enable (mstatus.MIE)
//  sw_clear_i    in   NUM_SRC      one-cycle strobe, clears edge-pending bits
//  irq_req_o     out  1            interrupt request to the core FSM
//  irq_id_o      out  ID_W         index of the requested / in-service source
//  irq_cause_o   out  `size_X_LEN  {1'b1, zero-extended CAUSE_BASE+irq_id_o}
//  irq_ack_i     in   1            core accepted the request (handler entry)
//  irq_done_i    in   1            MRET retired
//  pending_o     out  NUM_SRC      pending vector, readable as mip
//  in_service_o  out  1            handler active
// BEHAVIOUR
//  Reset (synchronous): every output is 0; state = IDLE; pending = 0; src_q = 0.
//  Pending bits:
//   - Edge source: set on irq_src_i & ~src_q. Cleared by sw_clear_i[i], or by irq_ack_i while
//     irq_id_o == i. If a set and a clear happen in the same cycle, the set wins.
//   - Level source: pending[i] <= irq_src_i[i]. sw_clear_i and ack have no effect on it.
//  Eligibility: elig = pending & enable_mask_i, qualified by global_en_i.
//   - Lowest set index wins; index 0 has the highest priority.
//  FSM states: IDLE, REQ, SERVICE.
//   - IDLE -> REQ when elig != 0. The winner index is latched into irq_id_o on the same edge.
//   - REQ -> SERVICE on irq_ack_i. The latched source's edge-pending bit clears on this edge.
//   - REQ -> IDLE (request withdrawn) when the latched source is no longer eligible and ack is
//     low. This covers a disabled mask, a cleared global enable, or a sw_clear.
//   - A higher-priority source arriving while in REQ does not replace irq_id_o; it wins the
//     next arbitration.
//   - SERVICE -> IDLE on irq_done_i. The controller does not nest: no request is raised while
//     in SERVICE.
//   - irq_done_i in IDLE or REQ is ignored. irq_ack_i outside REQ is ignored.
//   - Undefined state encodings go to IDLE.
//  Outputs:
//   - irq_req_o = (state == REQ); in_service_o = (state == SERVICE).
//   - irq_id_o and irq_cause_o hold stable through REQ and SERVICE, and are 0 in IDLE.
//  Latency: src rises before edge E0 -> pending after E0 -> irq_req_o high after E1 (2 cycles).
//   - After irq_done_i at edge En, the next request can assert after En+1 at the earliest.
//  Width: irq_cause_o[`size_X_LEN-1] = 1; the lower bits are CAUSE_BASE+id, zero-extended.
//  Reset mid-operation: returns to IDLE in one cycle from any state and drops the request.
//   - Pending edges are lost; level sources re-latch after reset deasserts.
// TESTING
//  1 Edge on src0 with mask=0x01, global=1 -> irq_req_o high 2 cycles later, irq_id_o=0,
//    irq_cause_o=0x80000010.
//  2 src3 and src5 both pending, both enabled -> id=3 first; after ack+done, id=5
//    (cause 0x80000015).
//  3 REQ on src2, then global_en_i dropped before ack -> irq_req_o low next cycle,
//    pending_o[2] still 1.
//  4 Edge on src0 in the same cycle as ack of id 0 -> pending_o[0] stays 1 and is re-requested
//    after irq_done_i.
//  5 Level src1 held high through SERVICE -> no request until done; request again 2 cycles
//    after done.
//  6 reset asserted in SERVICE with pending=0x09 -> next cycle all outputs 0 and pending=0.

Source files
------------

// File: rtl/irq_priority_ctrl.sv
// Machine-level interrupt controller: latches edge/level sources into a pending vector,
// arbitrates by fixed priority (index 0 highest) and tracks one request through MRET.
`ifndef size_X_LEN
`define size_X_LEN 32
`endif

module irq_priority_ctrl #(
  parameter int                 NUM_SRC    = 8,
  parameter logic [NUM_SRC-1:0] EDGE_MASK  = 8'b00000001,
  parameter int                 CAUSE_BASE = 16,
  parameter int                 ID_W       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       irq_src_i,
  input  logic [NUM_SRC-1:0]       enable_mask_i,
  input  logic                     global_en_i,
  input  logic [NUM_SRC-1:0]       sw_clear_i,
  output logic                     irq_req_o,
  output logic [ID_W-1:0]          irq_id_o,
  output logic [`size_X_LEN-1:0]   irq_cause_o,
  input  logic                     irq_ack_i,
  input  logic                     irq_done_i,
  output logic [NUM_SRC-1:0]       pending_o,
  output logic                     in_service_o
);

  localparam int XLEN = `size_X_LEN;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [ID_W-1:0]    id_reg, id_next;
  logic [NUM_SRC-1:0] src_q_reg;
  logic [NUM_SRC-1:0] pending_reg, pending_next;
  logic [NUM_SRC-1:0] elig;
  logic [ID_W-1:0]    win_id;
  logic               ack_fire;
  logic               unused_clr;

  assign ack_fire = (state_reg == REQ) && irq_ack_i;

  // Software clears only reach edge-latched sources; level bits just mirror the line.
  assign unused_clr = ^(sw_clear_i & ~EDGE_MASK);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_pend
      if (EDGE_MASK[gi]) begin : g_edge
        logic set_w, clr_w;
        assign set_w = irq_src_i[gi] & ~src_q_reg[gi];
        assign clr_w = sw_clear_i[gi] | (ack_fire && (id_reg == ID_W'(gi)));
        // A new edge in the same cycle as a clear must not be lost.
        assign pending_next[gi] = set_w | (pending_reg[gi] & ~clr_w);
      end else begin : g_level
        assign pending_next[gi] = irq_src_i[gi];
      end
    end
  endgenerate

  assign elig = pending_reg & enable_mask_i & {NUM_SRC{global_en_i}};

  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) win_id = ID_W'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    case (state_reg)
      IDLE: begin
        if (elig != '0) begin
          state_next = REQ;
          id_next    = win_id;
        end
      end
      REQ: begin
        // Ack takes precedence over withdrawal; a higher-priority arrival waits.
        if (irq_ack_i) begin
          state_next = SERVICE;
        end else if (!elig[id_reg]) begin
          state_next = IDLE;
          id_next    = '0;
        end
      end
      SERVICE: begin
        if (irq_done_i) begin
          state_next = IDLE;
          id_next    = '0;
        end
      end
      default: begin
        state_next = IDLE;
        id_next    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      id_reg      <= '0;
      src_q_reg   <= '0;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      id_reg      <= id_next;
      src_q_reg   <= irq_src_i;
      pending_reg <= pending_next;
    end
  end

  logic            active;
  logic [XLEN-2:0] cause_low;

  assign active       = (state_reg == REQ) || (state_reg == SERVICE);
  assign cause_low    = (XLEN-1)'(CAUSE_BASE) + (XLEN-1)'(id_reg);
  assign irq_req_o    = (state_reg == REQ);
  assign in_service_o = (state_reg == SERVICE);
  assign irq_id_o     = id_reg;
  assign irq_cause_o  = active ? {1'b1, cause_low} : '0;
  assign pending_o    = pending_reg;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Scoreboard bench for irq_priority_ctrl: each step queues the expected post-edge
// outputs, and the monitor side pops and compares them one cycle later.
module tb_irq_priority_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_src_i;
  logic [7:0]  enable_mask_i;
  logic        global_en_i;
  logic [7:0]  sw_clear_i;
  logic        irq_req_o;
  logic [3:0]  irq_id_o;
  logic [31:0] irq_cause_o;
  logic        irq_ack_i;
  logic        irq_done_i;
  logic [7:0]  pending_o;
  logic        in_service_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       req;
    logic [3:0] id;
    logic [7:0] pend;
    logic       svc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  irq_priority_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .irq_src_i     (irq_src_i),
    .enable_mask_i (enable_mask_i),
    .global_en_i   (global_en_i),
    .sw_clear_i    (sw_clear_i),
    .irq_req_o     (irq_req_o),
    .irq_id_o      (irq_id_o),
    .irq_cause_o   (irq_cause_o),
    .irq_ack_i     (irq_ack_i),
    .irq_done_i    (irq_done_i),
    .pending_o     (pending_o),
    .in_service_o  (in_service_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  // Queue the expected outputs after the coming edge, then pop and compare them.
  task automatic tick(input string tag, input logic e_req, input logic [3:0] e_id,
                      input logic [7:0] e_pend, input logic e_svc);
    exp_t        e;
    string       t;
    logic [31:0] e_cause;
    e.req = e_req; e.id = e_id; e.pend = e_pend; e.svc = e_svc;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      e_cause = (e.req || e.svc) ? (32'h8000_0000 | (32'd16 + {28'd0, e.id})) : 32'd0;
      check_val({t, "_req"},   {31'd0, irq_req_o},    {31'd0, e.req});
      check_val({t, "_id"},    {28'd0, irq_id_o},     {28'd0, e.id});
      check_val({t, "_cause"}, irq_cause_o,           e_cause);
      check_val({t, "_pend"},  {24'd0, pending_o},    {24'd0, e.pend});
      check_val({t, "_svc"},   {31'd0, in_service_o}, {31'd0, e.svc});
      $display("step %-10s req=%0d id=%0d cause=0x%08h pend=0x%02h svc=%0d",
               t, irq_req_o, irq_id_o, irq_cause_o, pending_o, in_service_o);
    end
  endtask

  initial begin
    reset = 1'b1; irq_src_i = '0; enable_mask_i = '0; global_en_i = 1'b0;
    sw_clear_i = '0; irq_ack_i = 1'b0; irq_done_i = 1'b0;
    tick("rst", 0, 0, 8'h00, 0);
    reset = 1'b0;
    tick("idle", 0, 0, 8'h00, 0);

    // 1: edge on src0, request two edges after the rising line
    irq_src_i = 8'h01; enable_mask_i = 8'h01; global_en_i = 1'b1;
    tick("t1_e0", 0, 0, 8'h01, 0);
    tick("t1_e1", 1, 0, 8'h01, 0);
    check_val("t1_cause_lit", irq_cause_o, 32'h8000_0010);
    irq_ack_i = 1'b1;
    tick("t1_ack", 0, 0, 8'h00, 1);
    irq_ack_i = 1'b0;
    tick("t1_svc", 0, 0, 8'h00, 1);
    irq_done_i = 1'b1;
    tick("t1_done", 0, 0, 8'h00, 0);
    irq_done_i = 1'b0; irq_src_i = 8'h00;
    tick("t1_idle", 0, 0, 8'h00, 0);

    // 2: src3 and src5 pending, lower index first
    irq_src_i = 8'h28; enable_mask_i = 8'h28;
    tick("t2_pend", 0, 0, 8'h28, 0);
    tick("t2_req3", 1, 3, 8'h28, 0);
    irq_ack_i = 1'b1;
    tick("t2_ack3", 0, 3, 8'h28, 1);
    irq_ack_i = 1'b0; irq_src_i = 8'h20;
    tick("t2_svc3", 0, 3, 8'h20, 1);
    irq_done_i = 1'b1;
    tick("t2_done3", 0, 0, 8'h20, 0);
    irq_done_i = 1'b0;
    tick("t2_req5", 1, 5, 8'h20, 0);
    check_val("t2_cause_lit", irq_cause_o, 32'h8000_0015);
    irq_ack_i = 1'b1;
    tick("t2_ack5", 0, 5, 8'h20, 1);
    irq_ack_i = 1'b0; irq_src_i = 8'h00; irq_done_i = 1'b1;
    tick("t2_done5", 0, 0, 8'h00, 0);
    irq_done_i = 1'b0;

    // 3: global enable dropped during REQ withdraws the request
    irq_src_i = 8'h04; enable_mask_i = 8'h04;
    tick("t3_pend", 0, 0, 8'h04, 0);
    tick("t3_req2", 1, 2, 8'h04, 0);
    global_en_i = 1'b0;
    tick("t3_wdraw", 0, 0, 8'h04, 0);
    tick("t3_gated", 0, 0, 8'h04, 0);
    global_en_i = 1'b1;
    tick("t3_rereq", 1, 2, 8'h04, 0);
    irq_src_i = 8'h00; enable_mask_i = 8'h00;
    tick("t3_mask", 0, 0, 8'h00, 0);

    // 4: new edge on src0 coinciding with its ack keeps pending set
    irq_src_i = 8'h01; enable_mask_i = 8'h01;
    tick("t4_pend", 0, 0, 8'h01, 0);
    tick("t4_req", 1, 0, 8'h01, 0);
    irq_src_i = 8'h00;
    tick("t4_hold", 1, 0, 8'h01, 0);
    irq_src_i = 8'h01; irq_ack_i = 1'b1;
    tick("t4_ackedge", 0, 0, 8'h01, 1);
    irq_ack_i = 1'b0;
    tick("t4_svc", 0, 0, 8'h01, 1);
    irq_done_i = 1'b1;
    tick("t4_done", 0, 0, 8'h01, 0);
    irq_done_i = 1'b0;
    tick("t4_rereq", 1, 0, 8'h01, 0);
    irq_ack_i = 1'b1;
    tick("t4_ack2", 0, 0, 8'h00, 1);
    irq_ack_i = 1'b0; irq_done_i = 1'b1;
    tick("t4_done2", 0, 0, 8'h00, 0);
    irq_done_i = 1'b0; irq_src_i = 8'h00;
    tick("t4_idle", 0, 0, 8'h00, 0);

    // 5: level src1 held through service, no nesting, re-request after done
    irq_src_i = 8'h02; enable_mask_i = 8'h02;
    tick("t5_pend", 0, 0, 8'h02, 0);
    tick("t5_req", 1, 1, 8'h02, 0);
    irq_ack_i = 1'b1;
    tick("t5_ack", 0, 1, 8'h02, 1);
    irq_ack_i = 1'b0;
    tick("t5_svc_a", 0, 1, 8'h02, 1);
    tick("t5_svc_b", 0, 1, 8'h02, 1);
    irq_done_i = 1'b1;
    tick("t5_done", 0, 0, 8'h02, 0);
    irq_done_i = 1'b0;
    tick("t5_rereq", 1, 1, 8'h02, 0);
    irq_ack_i = 1'b1;
    tick("t5_ack2", 0, 1, 8'h02, 1);
    irq_ack_i = 1'b0; irq_src_i = 8'h00; irq_done_i = 1'b1;
    tick("t5_done2", 0, 0, 8'h00, 0);
    irq_done_i = 1'b0;

    // 6: reset while in SERVICE with pending 0x09
    irq_src_i = 8'h09; enable_mask_i = 8'h09;
    tick("t6_pend", 0, 0, 8'h09, 0);
    tick("t6_req", 1, 0, 8'h09, 0);
    irq_ack_i = 1'b1;
    tick("t6_ack", 0, 0, 8'h08, 1);
    irq_ack_i = 1'b0; irq_src_i = 8'h08;
    tick("t6_low", 0, 0, 8'h08, 1);
    irq_src_i = 8'h09;
    tick("t6_edge", 0, 0, 8'h09, 1);
    reset = 1'b1;
    tick("t6_reset", 0, 0, 8'h00, 0);
    reset = 1'b0;
    tick("t6_relatch", 0, 0, 8'h09, 0);
    tick("t6_req2", 1, 0, 8'h09, 0);

    // 7: sw_clear of the requested edge source withdraws it; level bits ignore sw_clear
    sw_clear_i = 8'h01;
    tick("t7_clr", 1, 0, 8'h08, 0);
    sw_clear_i = 8'h00;
    tick("t7_wdraw", 0, 0, 8'h08, 0);
    tick("t7_req3", 1, 3, 8'h08, 0);
    sw_clear_i = 8'h08;
    tick("t7_lvlclr", 1, 3, 8'h08, 0);
    sw_clear_i = 8'h00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
